// File: rtl/d7s_mux_counter_if.sv
// ============================================================================
// d7s_mux_counter_if : control and display signals of the multiplexed counter
// Rev 1.0
// ============================================================================
`default_nettype none

interface d7s_mux_counter_if #(
  parameter int DIGITS = 3
);
  logic              i_en;
  logic              i_up_dn;
  logic              i_clr;
  logic              i_blank_lz;
  logic [6:0]        o_seg;
  logic [DIGITS-1:0] o_dig_sel;
  logic              o_wrap;

  modport master (
    output i_en, i_up_dn, i_clr, i_blank_lz,
    input  o_seg, o_dig_sel, o_wrap
  );

  modport slave (
    input  i_en, i_up_dn, i_clr, i_blank_lz,
    output o_seg, o_dig_sel, o_wrap
  );
endinterface

`default_nettype wire

// File: rtl/d7s_mux_counter.sv
// ============================================================================
// d7s_mux_counter : N-digit BCD up/down counter with scanned 7-segment output
// Rev 1.0
// ============================================================================
`default_nettype none

module d7s_mux_counter #(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 12_000_000,
  parameter int SCAN_DIV = 10_000
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  d7s_mux_counter_if.slave  bus
);

  localparam int PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
  localparam int CNT_W  = 4 * DIGITS;

  localparam logic [PRE_W-1:0]  c_PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [SLOT_W-1:0] c_SLOT_MAX = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  c_IDX_MAX  = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]  r_pre;
  logic [SLOT_W-1:0] r_slot;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_dig_sel;
  logic              r_wrap;

  logic              w_step;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_carry_out;
  logic [DIGITS-1:0] w_zero_hi;
  logic [3:0]        w_cur_d;
  logic              w_cur_zero_hi;
  logic [DIGITS-1:0] w_sel;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h3F;
      4'd1:    f_decode = 7'h06;
      4'd2:    f_decode = 7'h5B;
      4'd3:    f_decode = 7'h4F;
      4'd4:    f_decode = 7'h66;
      4'd5:    f_decode = 7'h6D;
      4'd6:    f_decode = 7'h7D;
      4'd7:    f_decode = 7'h07;
      4'd8:    f_decode = 7'h7F;
      4'd9:    f_decode = 7'h6F;
      default: f_decode = 7'h00;
    endcase
  endfunction

  assign w_step = bus.i_en && (r_pre == c_PRE_MAX);

  // Ripple the increment/decrement through the nibbles; the final carry is the wrap.
  always_comb begin : p_next
    logic [3:0] d;
    logic       cy;
    d         = 4'd0;
    cy        = 1'b1;
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < DIGITS; i++) begin
      d = r_cnt[4*i +: 4];
      if (cy) begin
        if (bus.i_up_dn) begin
          if (d == 4'd9) d = 4'd0;
          else begin
            d  = d + 4'd1;
            cy = 1'b0;
          end
        end else begin
          if (d == 4'd0) d = 4'd9;
          else begin
            d  = d - 4'd1;
            cy = 1'b0;
          end
        end
      end
      w_cnt_nxt[4*i +: 4] = d;
    end
    w_carry_out = cy;
  end

  // w_zero_hi[i]: digit i and every more significant digit are zero.
  always_comb begin : p_zero
    logic acc;
    acc       = 1'b1;
    w_zero_hi = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc          = acc && (r_cnt[4*i +: 4] == 4'd0);
      w_zero_hi[i] = acc;
    end
  end

  always_comb begin
    w_cur_d       = 4'd0;
    w_cur_zero_hi = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_d       = r_cnt[4*i +: 4];
        w_cur_zero_hi = w_zero_hi[i];
      end
    end
  end

  assign w_sel = DIGITS'(1) << r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (bus.i_clr) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_step && w_carry_out;
      if (w_step) begin
        r_pre <= '0;
        r_cnt <= w_cnt_nxt;
      end else if (bus.i_en) begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
      r_idx  <= '0;
    end else if (r_slot == c_SLOT_MAX) begin
      r_slot <= '0;
      r_idx  <= (r_idx == c_IDX_MAX) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_slot <= r_slot + SLOT_W'(1);
    end
  end

  // Slot cycle 0 is a dark gap so the previous digit's segments never ghost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg     <= 7'h00;
      r_dig_sel <= '0;
    end else if (r_slot == '0) begin
      r_seg     <= 7'h00;
      r_dig_sel <= '0;
    end else begin
      r_dig_sel <= w_sel;
      if (bus.i_blank_lz && (r_idx != '0) && w_cur_zero_hi) r_seg <= 7'h00;
      else                                                  r_seg <= f_decode(w_cur_d);
    end
  end

  assign bus.o_seg     = r_seg;
  assign bus.o_dig_sel = r_dig_sel;
  assign bus.o_wrap    = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_d7s_mux_counter.sv
// ============================================================================
// tb_d7s_mux_counter : directed checks of count, wrap, blanking and scan order
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_d7s_mux_counter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;

  d7s_mux_counter_if #(.DIGITS(3)) bus ();

  d7s_mux_counter #(
    .DIGITS  (3),
    .TICK_DIV(4),
    .SCAN_DIV(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for the lit slot of digit idx, then compare its segments.
  task automatic check_digit(input int idx, input logic [6:0] exp, input string tag);
    logic [2:0] want;
    bit         found;
    want  = 3'(1 << idx);
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(posedge clk);
      #1;
      if (bus.o_dig_sel === want) found = 1'b1;
    end
    if (!found) begin
      n_vec++;
      n_fail++;
      $error("FAIL %s: digit %0d slot not seen, dig_sel %b expected %b", tag, idx, bus.o_dig_sel, want);
    end else begin
      chk(tag, {1'b0, bus.o_seg}, {1'b0, exp});
    end
  endtask

  initial begin
    logic [2:0] pat [12];
    pat = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010,
            3'b000, 3'b100, 3'b100, 3'b100};
    n_vec  = 0;
    n_fail = 0;

    rst_n          = 1'b0;
    bus.i_en       = 1'b0;
    bus.i_up_dn    = 1'b1;
    bus.i_clr      = 1'b0;
    bus.i_blank_lz = 1'b0;
    tick(3);
    chk("rst_seg",  {1'b0, bus.o_seg}, 8'h00);
    chk("rst_dig",  {5'b0, bus.o_dig_sel}, 8'h00);
    chk("rst_wrap", {7'b0, bus.o_wrap}, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk("scan_dig", {5'b0, bus.o_dig_sel}, {5'b0, pat[k]});
      chk("scan_seg", {1'b0, bus.o_seg}, (pat[k] == 3'b000) ? 8'h00 : 8'h3F);
    end
    bus.i_blank_lz = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk("blank_dig", {5'b0, bus.o_dig_sel}, {5'b0, pat[k]});
      chk("blank_seg", {1'b0, bus.o_seg}, (pat[k] == 3'b001) ? 8'h3F : 8'h00);
    end

    // Up counting: three enabled edges do not step, the fourth does.
    bus.i_blank_lz = 1'b0;
    bus.i_up_dn    = 1'b1;
    bus.i_en       = 1'b1;
    tick(3);
    bus.i_en = 1'b0;
    check_digit(0, 7'h3F, "up_3edges_d0");
    bus.i_en = 1'b1;
    tick(1);
    bus.i_en = 1'b0;
    check_digit(0, 7'h06, "up_4edges_d0");
    bus.i_en = 1'b1;
    tick(44);
    bus.i_en = 1'b0;
    check_digit(0, 7'h5B, "up12_d0");
    check_digit(1, 7'h06, "up12_d1");
    check_digit(2, 7'h3F, "up12_d2");
    bus.i_blank_lz = 1'b1;
    check_digit(2, 7'h00, "up12_d2_blank");
    check_digit(1, 7'h06, "up12_d1_noblank");

    // Prescaler holds through 10 disabled cycles.
    bus.i_en = 1'b1;
    tick(3);
    bus.i_en = 1'b0;
    tick(10);
    check_digit(0, 7'h5B, "hold_d0");
    bus.i_en = 1'b1;
    tick(1);
    bus.i_en = 1'b0;
    check_digit(0, 7'h4F, "hold_step_d0");

    // clr resets count and prescaler.
    bus.i_en = 1'b1;
    tick(2);
    bus.i_clr = 1'b1;
    tick(1);
    bus.i_clr = 1'b0;
    tick(3);
    bus.i_en = 1'b0;
    check_digit(0, 7'h3F, "clr_d0");
    check_digit(1, 7'h00, "clr_d1_blank");

    // clr collides with a wrapping down step.
    bus.i_en = 1'b1;
    tick(3);
    bus.i_up_dn = 1'b0;
    bus.i_clr   = 1'b1;
    tick(1);
    chk("clr_step_wrap", {7'b0, bus.o_wrap}, 8'h00);
    bus.i_clr = 1'b0;
    bus.i_en  = 1'b0;
    tick(1);
    chk("clr_step_wrap2", {7'b0, bus.o_wrap}, 8'h00);
    bus.i_blank_lz = 1'b0;
    check_digit(0, 7'h3F, "clr_step_d0");
    check_digit(2, 7'h3F, "clr_step_d2");

    // Down wrap 000 -> 999.
    bus.i_blank_lz = 1'b1;
    bus.i_up_dn    = 1'b0;
    bus.i_en       = 1'b1;
    tick(3);
    chk("dn_wrap_pre", {7'b0, bus.o_wrap}, 8'h00);
    tick(1);
    chk("dn_wrap_pulse", {7'b0, bus.o_wrap}, 8'h01);
    bus.i_en = 1'b0;
    tick(1);
    chk("dn_wrap_post", {7'b0, bus.o_wrap}, 8'h00);
    check_digit(0, 7'h6F, "dn_wrap_d0");
    check_digit(1, 7'h6F, "dn_wrap_d1");
    check_digit(2, 7'h6F, "dn_wrap_d2");

    // Up wrap 999 -> 000.
    bus.i_up_dn = 1'b1;
    bus.i_en    = 1'b1;
    tick(3);
    chk("up_wrap_pre", {7'b0, bus.o_wrap}, 8'h00);
    tick(1);
    chk("up_wrap_pulse", {7'b0, bus.o_wrap}, 8'h01);
    bus.i_en = 1'b0;
    tick(1);
    chk("up_wrap_post", {7'b0, bus.o_wrap}, 8'h00);
    bus.i_blank_lz = 1'b0;
    check_digit(0, 7'h3F, "up_wrap_d0");
    check_digit(1, 7'h3F, "up_wrap_d1");
    check_digit(2, 7'h3F, "up_wrap_d2");

    // Count up to 100, then borrow down to 099.
    bus.i_en = 1'b1;
    tick(400);
    bus.i_en = 1'b0;
    chk("to100_wrap", {7'b0, bus.o_wrap}, 8'h00);
    bus.i_blank_lz = 1'b1;
    check_digit(2, 7'h06, "c100_d2");
    check_digit(1, 7'h3F, "c100_d1");
    check_digit(0, 7'h3F, "c100_d0");
    bus.i_up_dn = 1'b0;
    bus.i_en    = 1'b1;
    tick(4);
    bus.i_en = 1'b0;
    check_digit(2, 7'h00, "c099_d2");
    check_digit(1, 7'h6F, "c099_d1");
    check_digit(0, 7'h6F, "c099_d0");

    // Asynchronous reset in the middle of a lit slot.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_seg", {1'b0, bus.o_seg}, 8'h00);
    chk("async_rst_dig", {5'b0, bus.o_dig_sel}, 8'h00);
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    check_digit(0, 7'h3F, "post_rst_d0");
    check_digit(1, 7'h00, "post_rst_d1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
